// File: rtl/ifetch_unit.sv
// ifetch_unit: fetch responder between pc_gen and instruction memory.
// Credit-limited word reads, in-order response buffer, flush drops stale reads.
module ifetch_unit #(
    parameter int xlen      = 32,
    parameter int MAX_OUTST = 2,
    parameter int BUF_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            next_pc_valide,
    input  logic [xlen-1:0] next_pc,
    output logic            pc_ready_o,
    input  logic            flush,
    output logic [xlen-1:0] instruction,
    output logic            instr_fault_o,
    output logic            instr_valid_o,
    input  logic            ok_o,
    output logic            mem_req_o,
    output logic [xlen-1:0] mem_addr_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [xlen-1:0] mem_rdata_i
);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_e;

    state_e               state_q, state_d;
    logic                 req_q, req_d;
    logic [xlen-1:0]      addr_q, addr_d;
    logic [7:0]           outst_q, outst_d;
    logic [7:0]           drop_q, drop_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [PW-1:0]        wptr_q, wptr_d;
    logic [PW-1:0]        rptr_q, rptr_d;
    logic [xlen-1:0]      data_q [BUF_DEPTH];
    logic [xlen-1:0]      data_d [BUF_DEPTH];
    logic [BUF_DEPTH-1:0] flt_q, flt_d;
    logic                 live_q, live_d;

    logic       aligned, accept, gnt_fire, gnt_live, gnt_stale;
    logic       rv_drop, rv_ret, push_ret, push_flt, push, pop;
    logic [7:0] outst_n, drop_n;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: DRAIN holds off new fetches until stale reads are gone
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (flush)                  state_d = (drop_d != '0) ? DRAIN : IDLE;
                else if (accept && aligned) state_d = REQ;
            end
            REQ: begin
                if (flush)         state_d = DRAIN;
                else if (gnt_fire) state_d = IDLE;
            end
            DRAIN: begin
                if (drop_d == '0 && !req_d) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; a misaligned fetch waits for outst=0 so it cannot overtake reads
    always_comb begin
        aligned       = (next_pc[1:0] == 2'b00);
        pc_ready_o    = live_q && (state_q == IDLE) && !req_q && !flush
                        && (outst_q < 8'(MAX_OUTST))
                        && ((cnt_q + outst_q) < 8'(BUF_DEPTH))
                        && (aligned || (outst_q == '0));
        instr_valid_o = (cnt_q != '0);
        instruction   = instr_valid_o ? data_q[rptr_q] : '0;
        instr_fault_o = instr_valid_o && flt_q[rptr_q];
        mem_req_o     = req_q;
        mem_addr_o    = addr_q;
    end

    // Credit, drop and buffer bookkeeping
    always_comb begin
        accept    = next_pc_valide && pc_ready_o;
        gnt_fire  = req_q && mem_gnt_i;
        gnt_live  = gnt_fire && (state_q != DRAIN);
        gnt_stale = gnt_fire && (state_q == DRAIN);
        rv_drop   = mem_rvalid_i && (drop_q != '0);
        rv_ret    = mem_rvalid_i && (drop_q == '0) && (outst_q != '0);
        outst_n   = outst_q + {7'b0, gnt_live} - {7'b0, rv_ret};
        drop_n    = drop_q + {7'b0, gnt_stale} - {7'b0, rv_drop};
        push_ret  = rv_ret && !flush;
        push_flt  = accept && !aligned;
        push      = push_ret || push_flt;
        pop       = instr_valid_o && ok_o && !flush;

        live_d  = 1'b1;
        req_d   = req_q;
        addr_d  = addr_q;
        outst_d = outst_n;
        drop_d  = drop_n;
        cnt_d   = cnt_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        data_d  = data_q;
        flt_d   = flt_q;

        if (accept && aligned) begin
            req_d  = 1'b1;
            addr_d = {next_pc[xlen-1:2], 2'b00};
        end else if (gnt_fire) begin
            req_d = 1'b0;
        end

        if (flush) begin
            outst_d = '0;
            drop_d  = drop_n + outst_n;
            cnt_d   = '0;
            wptr_d  = '0;
            rptr_d  = '0;
        end else begin
            if (push) begin
                data_d[wptr_q] = push_flt ? xlen'(32'h13) : mem_rdata_i;
                flt_d[wptr_q]  = push_flt;
                wptr_d         = ptr_inc(wptr_q);
            end
            if (pop) rptr_d = ptr_inc(rptr_q);
            cnt_d = cnt_q + {7'b0, push} - {7'b0, pop};
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q  <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            outst_q <= '0;
            drop_q  <= '0;
            cnt_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            data_q  <= '{default: '0};
            flt_q   <= '0;
        end else begin
            live_q  <= live_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            data_q  <= data_d;
            flt_q   <= flt_d;
        end
    end

    rvalid_expected: assert property (@(posedge clk) disable iff (!rst_n)
        mem_rvalid_i |-> (outst_q != '0 || drop_q != '0));

endmodule
